instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch sequencer: the producer that feeds the instruction register.
//   Holds the program counter and reads one WORD_W-bit word from instruction memory per request.
//   Presents that word on ir_datain and strobes ir_write_en for one cycle.
//   The IR splits the word as opcode [16:12] and operand [11:0].
//   Sits between the control unit (fetch_req/jump) and the synchronous instruction RAM.
// PARAMETERS
//   ADDR_W   12  PC / memory address width
//   WORD_W   17  instruction word width (opcode 5b + operand 12b)
//   MEM_LAT  1   memory read latency in cycles (legal range 1..7)
// PORTS
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous reset, active-high
//   fetch_req    in   1        control unit requests next instruction (pulse or level)
//   jump_en      in   1        load PC from jump_addr
//   jump_addr    in   ADDR_W   branch target
//   mem_addr     out  ADDR_W   instruction memory address (registered)
//   mem_rd       out  1        memory read strobe, 1 cycle per fetch
//   mem_rdata    in   WORD_W   memory read data
//   ir_datain    out  WORD_W   fetched word to IR (held between fetches)
//   ir_write_en  out  1        IR load strobe, 1 cycle per fetch
//   pc           out  ADDR_W   current program counter
//   busy         out  1        fetch in progress
//   fetch_done   out  1        1-cycle pulse, coincident with ir_write_en
// BEHAVIOUR
//   Reset (async, rst=1): all outputs are 0.
//     Reset clears: state=IDLE, pc, mem_addr, mem_rd, ir_datain, ir_write_en, busy, fetch_done.
//     Reset also clears the latency counter and the pending-jump register.
//   FSM states: IDLE -> ADDR -> WAIT -> LOAD -> IDLE.
//   IDLE: busy=0.
//     jump_en=1: pc <= jump_addr.
//     fetch_req=1: go to ADDR. If jump_en is also 1, the fetch targets jump_addr.
//   ADDR (1 cycle): mem_addr=pc, mem_rd=1, busy=1; latency counter loaded with MEM_LAT.
//   WAIT (MEM_LAT cycles): mem_rd=0. On the last WAIT edge, mem_rdata is captured into ir_datain.
//   LOAD (1 cycle): ir_write_en=1, fetch_done=1, busy=1.
//     At the end of LOAD: pc <= pc+1, modulo 2^ADDR_W (0xFFF wraps to 0x000).
//     If a jump is pending: pc <= pending address instead, and the pending flag clears.
//   Latency: fetch_req sampled high at edge E -> mem_rd high in cycle E+1.
//     ir_write_en is high in cycle E+2+MEM_LAT. Back-to-back fetch throughput is MEM_LAT+3 cycles.
//   fetch_req while busy: ignored, not queued. The control unit re-asserts it after fetch_done.
//   jump_en while busy: jump_addr latched as pending. The last jump_en before LOAD ends wins.
//     The in-flight fetch still completes from its original address.
//   jump_en during LOAD: also becomes the new pc, overriding the increment.
//   mem_addr holds its value after ADDR. ir_datain changes only on capture or reset.
//   Reset mid-fetch: aborts immediately. No ir_write_en is issued and the pending jump is lost.
// TESTING
//   1. Reset, mem[0]=17'h1_2ABC, fetch_req pulse -> mem_rd at cycle 1, addr 0.
//      Then ir_write_en and fetch_done at cycle 3 (MEM_LAT=1), ir_datain=17'h1_2ABC, pc becomes 1.
//   2. Four back-to-back fetches from pc=0xFFE -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
//      pc wraps to 0x000 after 0xFFF; one ir_write_en per fetch.
//   3. jump_en=1, jump_addr=0x100, with fetch_req in the same IDLE cycle.
//      -> mem_addr=0x100; pc=0x101 after LOAD.
//   4. jump_en to 0x200 during WAIT of a fetch at pc=5.
//      -> IR gets mem[5]; pc=0x200 (not 6); next fetch reads 0x200.
//   5. fetch_req held high during a busy fetch.
//      -> no extra mem_rd until after fetch_done; exactly one fetch per IDLE entry.
//   6. rst asserted in WAIT -> outputs 0 immediately, no ir_write_en.
//      A subsequent fetch reads address 0.
//      Repeat the suite with MEM_LAT=3: ir_write_en at cycle 5.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: holds the PC, issues one read per request to a
// synchronous instruction RAM and hands the returned word to the IR.
module instr_fetch #(
    parameter int ADDR_W  = 12,
    parameter int WORD_W  = 17,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] ir_datain,
    output logic              ir_write_en,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done
);

    // Handshake: fetch_req is accepted only in IDLE (level or pulse, never
    // queued); jump_en is taken on any cycle, applied at once in IDLE and
    // deferred to the end of LOAD while a fetch is in flight.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        lat_cnt;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              last_wait;

    assign last_wait = (state == S_WAIT) && (lat_cnt == 3'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fetch_req) state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_WAIT;
            S_WAIT: if (last_wait) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so they are 0 in reset.
    assign mem_rd      = (state == S_ADDR);
    assign ir_write_en = (state == S_LOAD);
    assign fetch_done  = (state == S_LOAD);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            mem_addr   <= '0;
            ir_datain  <= '0;
            lat_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (jump_en) pc <= jump_addr;
                    if (fetch_req) mem_addr <= jump_en ? jump_addr : pc;
                end
                S_ADDR, S_WAIT: begin
                    if (state == S_ADDR) lat_cnt <= 3'(MEM_LAT);
                    else                 lat_cnt <= lat_cnt - 3'd1;
                    if (jump_en) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= jump_addr;
                    end
                end
                S_LOAD: begin
                    // A jump seen in LOAD itself is the most recent and wins.
                    if (jump_en)         pc <= jump_addr;
                    else if (pend_valid) pc <= pend_addr;
                    else                 pc <= pc + ADDR_W'(1);
                    pend_valid <= 1'b0;
                end
                default: ;
            endcase
            if (last_wait) ir_datain <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (MEM_LAT=1 and MEM_LAT=3) run
// the same stimulus in lockstep, each against its own latency-matched RAM model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        jump_en;
    logic [11:0] jump_addr;

    logic [11:0] mem_addr_1, pc_1, mem_addr_3, pc_3;
    logic        mem_rd_1, ir_write_en_1, busy_1, fetch_done_1;
    logic        mem_rd_3, ir_write_en_3, busy_3, fetch_done_3;
    logic [16:0] mem_rdata_1, ir_datain_1, mem_rdata_3, ir_datain_3;

    logic [16:0] mem [4096];
    logic [16:0] pipe1;
    logic [16:0] pipe3 [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(12), .WORD_W(17), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .jump_en(jump_en),
        .jump_addr(jump_addr), .mem_addr(mem_addr_1), .mem_rd(mem_rd_1),
        .mem_rdata(mem_rdata_1), .ir_datain(ir_datain_1),
        .ir_write_en(ir_write_en_1), .pc(pc_1), .busy(busy_1),
        .fetch_done(fetch_done_1)
    );

    instr_fetch #(.ADDR_W(12), .WORD_W(17), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .jump_en(jump_en),
        .jump_addr(jump_addr), .mem_addr(mem_addr_3), .mem_rd(mem_rd_3),
        .mem_rdata(mem_rdata_3), .ir_datain(ir_datain_3),
        .ir_write_en(ir_write_en_3), .pc(pc_3), .busy(busy_3),
        .fetch_done(fetch_done_3)
    );

    // Synchronous RAM models: data for the address of cycle N appears in N+LAT.
    always @(posedge clk) begin
        pipe1    <= mem[mem_addr_1];
        pipe3[0] <= mem[mem_addr_3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata_1 = pipe1;
    assign mem_rdata_3 = pipe3[2];

    function automatic logic [16:0] pattern(input int i);
        logic [11:0] a;
        a = 12'(i);
        return {a[4:0] ^ 5'h15, a ^ 12'h5A5};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " zero1"}, {mem_addr_1, mem_rd_1, ir_write_en_1, busy_1, fetch_done_1, pc_1}, 32'd0);
        chk({tag, " ir1"}, 32'(ir_datain_1), 32'd0);
        chk({tag, " zero3"}, {mem_addr_3, mem_rd_3, ir_write_en_3, busy_3, fetch_done_3, pc_3}, 32'd0);
        chk({tag, " ir3"}, 32'(ir_datain_3), 32'd0);
    endtask

    // One fetch from IDLE; optional jump during the first WAIT cycle (cycle E+2).
    task automatic do_fetch(input string tag, input logic jmp, input logic [11:0] jaddr,
                            input logic mid, input logic [11:0] mid_addr,
                            input logic [11:0] exp_addr, input logic [16:0] exp_data,
                            input logic [11:0] exp_pc);
        int rd1 = 0, rd3 = 0, we1 = 0, we3 = 0, fd1 = 0, fd3 = 0;
        int cyc1 = -1, cyc3 = -1;
        fetch_req = 1'b1;
        jump_en   = jmp;
        jump_addr = jaddr;
        step();
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        chk({tag, " mem_rd1"}, 32'(mem_rd_1), 32'd1);
        chk({tag, " mem_rd3"}, 32'(mem_rd_3), 32'd1);
        chk({tag, " addr1"}, 32'(mem_addr_1), 32'(exp_addr));
        chk({tag, " addr3"}, 32'(mem_addr_3), 32'(exp_addr));
        rd1 = 1;
        rd3 = 1;
        for (int c = 2; c <= 11; c++) begin
            step();
            if (mid && c == 2) begin
                jump_en   = 1'b1;
                jump_addr = mid_addr;
            end else begin
                jump_en = 1'b0;
            end
            if (mem_rd_1) rd1++;
            if (mem_rd_3) rd3++;
            if (fetch_done_1) fd1++;
            if (fetch_done_3) fd3++;
            if (ir_write_en_1) begin
                we1++;
                cyc1 = c;
                chk({tag, " ir1"}, 32'(ir_datain_1), 32'(exp_data));
            end
            if (ir_write_en_3) begin
                we3++;
                cyc3 = c;
                chk({tag, " ir3"}, 32'(ir_datain_3), 32'(exp_data));
            end
        end
        chk({tag, " rd_cnt1"}, 32'(rd1), 32'd1);
        chk({tag, " rd_cnt3"}, 32'(rd3), 32'd1);
        chk({tag, " we_cnt1"}, 32'(we1), 32'd1);
        chk({tag, " we_cnt3"}, 32'(we3), 32'd1);
        chk({tag, " done_cnt1"}, 32'(fd1), 32'd1);
        chk({tag, " done_cnt3"}, 32'(fd3), 32'd1);
        chk({tag, " we_cycle1"}, 32'(cyc1), 32'd3);
        chk({tag, " we_cycle3"}, 32'(cyc3), 32'd5);
        chk({tag, " pc1"}, 32'(pc_1), 32'(exp_pc));
        chk({tag, " pc3"}, 32'(pc_3), 32'(exp_pc));
        chk({tag, " ir_hold1"}, 32'(ir_datain_1), 32'(exp_data));
        chk({tag, " ir_hold3"}, 32'(ir_datain_3), 32'(exp_data));
        chk({tag, " idle"}, {30'd0, busy_1, busy_3}, 32'd0);
    endtask

    initial begin
        int rd1, rd3, we1, we3;
        for (int i = 0; i < 4096; i++) mem[i] = pattern(i);
        mem[0] = 17'h1_2ABC;
        rst       = 1'b1;
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 12'h000;

        // 1: reset state, then first fetch from address 0
        #3;
        chk_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        chk_zero("post_reset");
        do_fetch("t1", 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 17'h1_2ABC, 12'h001);

        // 2: jump in IDLE to 0xFFE, then four fetches across the wrap
        jump_en   = 1'b1;
        jump_addr = 12'hFFE;
        step();
        jump_en = 1'b0;
        chk("t2 pc1_jump", 32'(pc_1), 32'h0FFE);
        chk("t2 pc3_jump", 32'(pc_3), 32'h0FFE);
        chk("t2 idle_after_jump", {30'd0, busy_1, busy_3}, 32'd0);
        do_fetch("t2a", 1'b0, 12'h000, 1'b0, 12'h000, 12'hFFE, pattern(12'hFFE), 12'hFFF);
        do_fetch("t2b", 1'b0, 12'h000, 1'b0, 12'h000, 12'hFFF, pattern(12'hFFF), 12'h000);
        do_fetch("t2c", 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 17'h1_2ABC, 12'h001);
        do_fetch("t2d", 1'b0, 12'h000, 1'b0, 12'h000, 12'h001, pattern(1), 12'h002);

        // 3: jump and fetch in the same IDLE cycle
        do_fetch("t3", 1'b1, 12'h100, 1'b0, 12'h000, 12'h100, pattern(12'h100), 12'h101);

        // 4: jump to 0x200 during WAIT of a fetch at pc=5
        jump_en   = 1'b1;
        jump_addr = 12'h005;
        step();
        jump_en = 1'b0;
        do_fetch("t4a", 1'b0, 12'h000, 1'b1, 12'h200, 12'h005, pattern(5), 12'h200);
        do_fetch("t4b", 1'b0, 12'h000, 1'b0, 12'h000, 12'h200, pattern(12'h200), 12'h201);

        // 5: fetch_req held high for 12 edges: one fetch per IDLE entry
        rd1 = 0; rd3 = 0; we1 = 0; we3 = 0;
        fetch_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (mem_rd_1) rd1++;
            if (mem_rd_3) rd3++;
            if (ir_write_en_1) we1++;
            if (ir_write_en_3) we3++;
        end
        fetch_req = 1'b0;
        chk("t5 rd_cnt1", 32'(rd1), 32'd3);
        chk("t5 rd_cnt3", 32'(rd3), 32'd2);
        chk("t5 we_cnt1", 32'(we1), 32'd3);
        chk("t5 we_cnt3", 32'(we3), 32'd2);
        chk("t5 pc1", 32'(pc_1), 32'h204);
        chk("t5 pc3", 32'(pc_3), 32'h203);
        step();
        chk("t5 idle", {30'd0, busy_1, busy_3}, 32'd0);

        // 6: reset asserted in WAIT aborts the fetch
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        chk("t6 in_wait", {30'd0, busy_1, busy_3}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("t6 async");
        we1 = 0;
        we3 = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (ir_write_en_1) we1++;
            if (ir_write_en_3) we3++;
        end
        chk("t6 no_we", 32'(we1 + we3), 32'd0);
        rst = 1'b0;
        step();
        chk_zero("t6 released");
        do_fetch("t6", 1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 17'h1_2ABC, 12'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
